// File: rtl/mod_vga_raster_gen.sv
// Parametrised VGA raster generator: request-side coordinate counters plus a
// delay line that aligns sync/blank/DE with colour from a fixed-latency pixel source.
module mod_vga_raster_gen #(
    parameter int RES_X      = 640,
    parameter int RES_Y      = 480,
    parameter int HFP        = 16,
    parameter int HPULSE     = 96,
    parameter int HBP        = 48,
    parameter int VFP        = 10,
    parameter int VPULSE     = 2,
    parameter int VBP        = 33,
    parameter int HSYNC_POL  = 0,
    parameter int VSYNC_POL  = 0,
    parameter int COLOR_BITS = 1,
    parameter int PIPE_DELAY = 0,
    parameter int COORD_W    = 10
) (
    input  logic                  clk_in_pixel,
    input  logic                  rst_in,
    input  logic [COLOR_BITS-1:0] vga_in_r,
    input  logic [COLOR_BITS-1:0] vga_in_g,
    input  logic [COLOR_BITS-1:0] vga_in_b,
    output logic [COORD_W-1:0]    vga_out_current_x,
    output logic [COORD_W-1:0]    vga_out_current_y,
    output logic                  vga_out_line_start,
    output logic                  vga_out_frame_start,
    output logic [7:0]            vga_out_frame_count,
    output logic [COLOR_BITS-1:0] vga_out_r,
    output logic [COLOR_BITS-1:0] vga_out_g,
    output logic [COLOR_BITS-1:0] vga_out_b,
    output logic                  vga_out_hsync,
    output logic                  vga_out_vsync,
    output logic                  vga_out_de,
    output logic                  vga_out_vblank
);

    localparam int H_TOTAL = RES_X + HFP + HPULSE + HBP;
    localparam int V_TOTAL = RES_Y + VFP + VPULSE + VBP;

    generate
        if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_bad_coord_w
            $error("mod_vga_raster_gen: H_TOTAL/V_TOTAL do not fit in COORD_W bits");
        end
        if (PIPE_DELAY < 0 || PIPE_DELAY > 15) begin : g_bad_pipe_delay
            $error("mod_vga_raster_gen: PIPE_DELAY must be 0..15");
        end
    endgenerate

    // One extra bit so porch ends equal to 2^COORD_W still compare correctly.
    localparam logic [COORD_W:0] H_LAST = (COORD_W+1)'(H_TOTAL - 1);
    localparam logic [COORD_W:0] V_LAST = (COORD_W+1)'(V_TOTAL - 1);
    localparam logic [COORD_W:0] VIS_X  = (COORD_W+1)'(RES_X);
    localparam logic [COORD_W:0] VIS_Y  = (COORD_W+1)'(RES_Y);
    localparam logic [COORD_W:0] HS_BEG = (COORD_W+1)'(RES_X + HFP);
    localparam logic [COORD_W:0] HS_END = (COORD_W+1)'(RES_X + HFP + HPULSE);
    localparam logic [COORD_W:0] VS_BEG = (COORD_W+1)'(RES_Y + VFP);
    localparam logic [COORD_W:0] VS_END = (COORD_W+1)'(RES_Y + VFP + VPULSE);
    localparam logic             HS_ACT = (HSYNC_POL != 0);
    localparam logic             VS_ACT = (VSYNC_POL != 0);

    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [7:0]         frame_count;
    logic [COORD_W:0]   x_ext;
    logic [COORD_W:0]   y_ext;
    logic               de_req;
    logic               hs_req;
    logic               vs_req;
    logic               vblank_req;
    logic [3:0]         req_vec;
    logic [3:0]         dly_vec;

    always_ff @(posedge clk_in_pixel) begin
        if (rst_in) begin
            x           <= '0;
            y           <= '0;
            frame_count <= '0;
        end else if (x_ext == H_LAST) begin
            x <= '0;
            if (y_ext == V_LAST) begin
                y           <= '0;
                frame_count <= frame_count + 8'd1;
            end else begin
                y <= y + COORD_W'(1);
            end
        end else begin
            x <= x + COORD_W'(1);
        end
    end

    assign x_ext      = {1'b0, x};
    assign y_ext      = {1'b0, y};
    assign de_req     = (x_ext < VIS_X) && (y_ext < VIS_Y);
    assign hs_req     = (x_ext >= HS_BEG) && (x_ext < HS_END);
    assign vs_req     = (y_ext >= VS_BEG) && (y_ext < VS_END);
    assign vblank_req = (y_ext >= VIS_Y);
    assign req_vec    = {de_req, hs_req, vs_req, vblank_req};

    assign vga_out_current_x   = x;
    assign vga_out_current_y   = y;
    assign vga_out_line_start  = (x == '0);
    assign vga_out_frame_start = (x == '0) && (y == '0);
    assign vga_out_frame_count = frame_count;

    // Stages carry active-high flags; polarity is applied only at the pins.
    generate
        if (PIPE_DELAY == 0) begin : g_no_delay
            assign dly_vec = req_vec;
        end else begin : g_delay
            logic [3:0] stage [PIPE_DELAY];
            always_ff @(posedge clk_in_pixel) begin
                if (rst_in) begin
                    for (int i = 0; i < PIPE_DELAY; i++) stage[i] <= '0;
                end else begin
                    stage[0] <= req_vec;
                    for (int i = 1; i < PIPE_DELAY; i++) stage[i] <= stage[i-1];
                end
            end
            assign dly_vec = stage[PIPE_DELAY-1];
        end
    endgenerate

    always_ff @(posedge clk_in_pixel) begin
        if (rst_in) begin
            vga_out_r      <= '0;
            vga_out_g      <= '0;
            vga_out_b      <= '0;
            vga_out_de     <= 1'b0;
            vga_out_vblank <= 1'b0;
            vga_out_hsync  <= ~HS_ACT;
            vga_out_vsync  <= ~VS_ACT;
        end else begin
            vga_out_r      <= dly_vec[3] ? vga_in_r : '0;
            vga_out_g      <= dly_vec[3] ? vga_in_g : '0;
            vga_out_b      <= dly_vec[3] ? vga_in_b : '0;
            vga_out_de     <= dly_vec[3];
            vga_out_hsync  <= dly_vec[2] ? HS_ACT : ~HS_ACT;
            vga_out_vsync  <= dly_vec[1] ? VS_ACT : ~VS_ACT;
            vga_out_vblank <= dly_vec[0];
        end
    end

endmodule

// File: tb/tb_mod_vga_raster_gen.sv
// Directed bench: default timing at PIPE_DELAY 0 and 3, plus a small raster
// (14x7, PIPE_DELAY 2, active-high hsync) for frame, wrap and reset checks.
module tb_mod_vga_raster_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_d;
    logic rst_s;
    int   n_assert = 0;
    int   n_fail   = 0;

    // Default timing, PIPE_DELAY=0
    logic       d0_in;
    logic [9:0] d0_x, d0_y;
    logic       d0_ls, d0_fs, d0_r, d0_g, d0_b, d0_hs, d0_vs, d0_de, d0_vb;
    logic [7:0] d0_fc;

    // Default timing, PIPE_DELAY=3
    logic       d3_in_r, d3_in_gb;
    logic [9:0] d3_x, d3_y;
    logic       d3_ls, d3_fs, d3_r, d3_g, d3_b, d3_hs, d3_vs, d3_de, d3_vb;
    logic [7:0] d3_fc;

    // Small raster, PIPE_DELAY=2
    logic [1:0] s_in;
    logic [3:0] s_x, s_y;
    logic       s_ls, s_fs, s_hs, s_vs, s_de, s_vb;
    logic [1:0] s_r, s_g, s_b;
    logic [7:0] s_fc;

    mod_vga_raster_gen #(.PIPE_DELAY(0)) dut_d0 (
        .clk_in_pixel(clk), .rst_in(rst_d),
        .vga_in_r(d0_in), .vga_in_g(d0_in), .vga_in_b(d0_in),
        .vga_out_current_x(d0_x), .vga_out_current_y(d0_y),
        .vga_out_line_start(d0_ls), .vga_out_frame_start(d0_fs),
        .vga_out_frame_count(d0_fc),
        .vga_out_r(d0_r), .vga_out_g(d0_g), .vga_out_b(d0_b),
        .vga_out_hsync(d0_hs), .vga_out_vsync(d0_vs),
        .vga_out_de(d0_de), .vga_out_vblank(d0_vb)
    );

    mod_vga_raster_gen #(.PIPE_DELAY(3)) dut_d3 (
        .clk_in_pixel(clk), .rst_in(rst_d),
        .vga_in_r(d3_in_r), .vga_in_g(d3_in_gb), .vga_in_b(d3_in_gb),
        .vga_out_current_x(d3_x), .vga_out_current_y(d3_y),
        .vga_out_line_start(d3_ls), .vga_out_frame_start(d3_fs),
        .vga_out_frame_count(d3_fc),
        .vga_out_r(d3_r), .vga_out_g(d3_g), .vga_out_b(d3_b),
        .vga_out_hsync(d3_hs), .vga_out_vsync(d3_vs),
        .vga_out_de(d3_de), .vga_out_vblank(d3_vb)
    );

    mod_vga_raster_gen #(
        .RES_X(8), .HFP(2), .HPULSE(3), .HBP(1),
        .RES_Y(4), .VFP(1), .VPULSE(1), .VBP(1),
        .HSYNC_POL(1), .VSYNC_POL(0), .COLOR_BITS(2),
        .PIPE_DELAY(2), .COORD_W(4)
    ) dut_s (
        .clk_in_pixel(clk), .rst_in(rst_s),
        .vga_in_r(s_in), .vga_in_g(s_in), .vga_in_b(s_in),
        .vga_out_current_x(s_x), .vga_out_current_y(s_y),
        .vga_out_line_start(s_ls), .vga_out_frame_start(s_fs),
        .vga_out_frame_count(s_fc),
        .vga_out_r(s_r), .vga_out_g(s_g), .vga_out_b(s_b),
        .vga_out_hsync(s_hs), .vga_out_vsync(s_vs),
        .vga_out_de(s_de), .vga_out_vblank(s_vb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // c = pixel cycles since release of rst_d; outputs lag requests by PIPE_DELAY+1.
    task automatic check_default(input int c);
        int k0, k3, xk, yk;
        logic de_e, hs_e, r_e;
        chk("d0_x", d0_x, c % 800);
        chk("d0_y", d0_y, c / 800);
        chk("d0_line_start", d0_ls, (c % 800) == 0);
        chk("d0_frame_start", d0_fs, c == 0);
        chk("d0_frame_count", d0_fc, 0);
        chk("d3_x", d3_x, c % 800);
        k0 = c - 1;
        de_e = 1'b0; hs_e = 1'b1;
        if (k0 >= 0) begin
            xk = k0 % 800;
            de_e = xk < 640;
            hs_e = !(xk >= 656 && xk <= 751);
        end
        chk("d0_hsync", d0_hs, hs_e);
        chk("d0_vsync", d0_vs, 1);
        chk("d0_de", d0_de, de_e);
        chk("d0_vblank", d0_vb, 0);
        chk("d0_r", d0_r, de_e);
        k3 = c - 4;
        de_e = 1'b0; hs_e = 1'b1; r_e = 1'b0;
        if (k3 >= 0) begin
            xk = k3 % 800;
            yk = k3 / 800;
            de_e = xk < 640;
            hs_e = !(xk >= 656 && xk <= 751);
            r_e = de_e && ((xk % 2) != (yk % 2));
        end
        chk("d3_de", d3_de, de_e);
        chk("d3_hsync", d3_hs, hs_e);
        chk("d3_r", d3_r, r_e);
        chk("d3_g", d3_g, 0);
    endtask

    task automatic check_small(input int c);
        int k, xk, yk;
        logic de_e, hs_e, vs_e, vb_e;
        chk("s_x", s_x, c % 14);
        chk("s_y", s_y, (c / 14) % 7);
        chk("s_line_start", s_ls, (c % 14) == 0);
        chk("s_frame_start", s_fs, (c % 98) == 0);
        chk("s_frame_count", s_fc, (c / 98) % 256);
        k = c - 3;
        de_e = 1'b0; hs_e = 1'b0; vs_e = 1'b1; vb_e = 1'b0;
        if (k >= 0) begin
            xk = k % 14;
            yk = (k / 14) % 7;
            de_e = xk < 8 && yk < 4;
            hs_e = xk >= 10 && xk <= 12;
            vs_e = yk != 5;
            vb_e = yk >= 4;
        end
        chk("s_de", s_de, de_e);
        chk("s_hsync", s_hs, hs_e);
        chk("s_vsync", s_vs, vs_e);
        chk("s_vblank", s_vb, vb_e);
        chk("s_r", s_r, de_e ? 3 : 0);
        chk("s_g", s_g, de_e ? 3 : 0);
        chk("s_b", s_b, de_e ? 3 : 0);
    endtask

    initial begin
        int nz;
        rst_d = 1'b1; rst_s = 1'b1;
        d0_in = 1'b1; d3_in_r = 1'b1; d3_in_gb = 1'b0; s_in = 2'b11;
        repeat (3) @(negedge clk);

        chk("rst_d0_x", d0_x, 0);
        chk("rst_d0_y", d0_y, 0);
        chk("rst_d0_fc", d0_fc, 0);
        chk("rst_d0_line_start", d0_ls, 1);
        chk("rst_d0_frame_start", d0_fs, 1);
        chk("rst_d0_hsync", d0_hs, 1);
        chk("rst_d0_vsync", d0_vs, 1);
        chk("rst_d0_de", d0_de, 0);
        chk("rst_d0_vblank", d0_vb, 0);
        chk("rst_d0_r", d0_r, 0);
        chk("rst_d3_de", d3_de, 0);
        chk("rst_d3_r", d3_r, 0);
        chk("rst_s_hsync", s_hs, 0);
        chk("rst_s_vsync", s_vs, 1);
        chk("rst_s_r", s_r, 0);

        // Default timing: three lines, pixel source returns parity of the
        // coordinate requested three cycles earlier.
        rst_d = 1'b0;
        for (int c = 0; c < 2400; c++) begin
            int j;
            check_default(c);
            if (c == 659) chk("d3_hsync_before_fall", d3_hs, 1);
            if (c == 660) chk("d3_hsync_fall", d3_hs, 0);
            j = c - 3;
            if (j < 0) d3_in_r = 1'b1;
            else d3_in_r = ((j % 800) % 2) != ((j / 800) % 2);
            @(negedge clk);
        end

        // Small raster: 256 frames plus part of one, all-ones colour input.
        rst_s = 1'b0;
        nz = 0;
        for (int c = 0; c < 25121; c++) begin
            check_small(c);
            chk("s_colour_outside_de", ((s_r != 0) || (s_g != 0) || (s_b != 0)) && !s_de, 0);
            if (s_r != 0) nz++;
            if (c > 0 && (c % 98) == 0) begin
                chk("s_colour_pixels_per_frame", nz, 32);
                nz = 0;
            end
            if (c == 294)   chk("s_fc_after_3_frames", s_fc, 3);
            if (c == 25087) chk("s_fc_before_wrap", s_fc, 255);
            if (c == 25088) begin
                chk("s_fc_wrap", s_fc, 0);
                chk("s_fs_at_wrap", s_fs, 1);
            end
            @(negedge clk);
        end

        // One-cycle reset at request x=5,y=2 with visible pixels in flight.
        chk("s_pre_reset_x", s_x, 5);
        chk("s_pre_reset_y", s_y, 2);
        rst_s = 1'b1;
        @(negedge clk);
        chk("s_mid_rst_x", s_x, 0);
        chk("s_mid_rst_y", s_y, 0);
        chk("s_mid_rst_fc", s_fc, 0);
        chk("s_mid_rst_de", s_de, 0);
        chk("s_mid_rst_hsync", s_hs, 0);
        chk("s_mid_rst_vsync", s_vs, 1);
        chk("s_mid_rst_r", s_r, 0);
        chk("s_mid_rst_frame_start", s_fs, 1);
        rst_s = 1'b0;
        for (int c = 0; c < 120; c++) begin
            check_small(c);
            if (c == 1 || c == 2) chk("s_no_stale_de", s_de, 0);
            if (c == 3) chk("s_de_rise_cycle3", s_de, 1);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
